// File: rtl/alu_seq_driver_if.sv
// rtl/alu_seq_driver_if.sv - request, ALU and response signal bundle for alu_seq_driver
interface alu_seq_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic        req_wide;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_op;
    logic        alu_cin;
    logic [31:0] alu_out;
    logic        alu_cout;
    logic        alu_eq;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_eq;

    modport slave (
        input  req_valid, req_op, req_wide, req_a, req_b, req_cin,
        input  alu_out, alu_cout, alu_eq, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, alu_cin,
        output rsp_valid, rsp_result, rsp_cout, rsp_eq
    );

    modport master (
        output req_valid, req_op, req_wide, req_a, req_b, req_cin,
        output alu_out, alu_cout, alu_eq, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, alu_cin,
        input  rsp_valid, rsp_result, rsp_cout, rsp_eq
    );
endinterface

// File: rtl/alu_seq_driver.sv
// rtl/alu_seq_driver.sv - sequences 32/64-bit add/NOR requests over a 32-bit ALU in one or two passes
module alu_seq_driver (
    input  logic               clk,
    input  logic               reset,
    alu_seq_driver_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state, state_nxt;
    logic [63:0] a_q, b_q, result_q;
    logic        op_q, wide_q, cin_q;
    logic        carry_lo, eq_lo;
    logic        cout_q, eq_q;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] alu_a, alu_b;
    logic        alu_op, alu_cin;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 1'b0;
        alu_cin   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_nxt = LO;
            end
            LO: begin
                alu_a     = a_q[31:0];
                alu_b     = b_q[31:0];
                alu_op    = op_q;
                alu_cin   = op_q ? 1'b0 : cin_q;
                state_nxt = wide_q ? HI : RESP;
            end
            HI: begin
                // Carry of the low pass chains into the high pass for add
                alu_a     = a_q[63:32];
                alu_b     = b_q[63:32];
                alu_op    = op_q;
                alu_cin   = op_q ? 1'b0 : carry_lo;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            wide_q   <= 1'b0;
            cin_q    <= 1'b0;
            result_q <= '0;
            carry_lo <= 1'b0;
            eq_lo    <= 1'b0;
            cout_q   <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        op_q   <= bus.req_op;
                        wide_q <= bus.req_wide;
                        cin_q  <= bus.req_cin;
                    end
                end
                LO: begin
                    result_q[31:0] <= bus.alu_out;
                    carry_lo       <= bus.alu_cout;
                    eq_lo          <= bus.alu_eq;
                    if (!wide_q) begin
                        result_q[63:32] <= '0;
                        cout_q          <= ~op_q & bus.alu_cout;
                        eq_q            <= bus.alu_eq;
                    end
                end
                HI: begin
                    result_q[63:32] <= bus.alu_out;
                    cout_q          <= ~op_q & bus.alu_cout;
                    eq_q            <= eq_lo & bus.alu_eq;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_eq     = eq_q;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_op     = alu_op;
    assign bus.alu_cin    = alu_cin;
endmodule

// File: tb/tb_alu_seq_driver.sv
// tb/tb_alu_seq_driver.sv - directed self-checking bench for alu_seq_driver
module tb_alu_seq_driver;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_driver_if bus();

    alu_seq_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference 32-bit ALU; NOR reports a junk carry of 1 so the driver must mask it
    logic [32:0] alu_sum;
    assign alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_cin};
    assign bus.alu_out  = bus.alu_op ? ~(bus.alu_a | bus.alu_b) : alu_sum[31:0];
    assign bus.alu_cout = bus.alu_op ? 1'b1 : alu_sum[32];
    assign bus.alu_eq   = (bus.alu_a == bus.alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic wide, input logic [63:0] a,
                         input logic [63:0] b, input logic cin);
        int t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: req_ready=%b expected 1", bus.req_ready);
        end
        bus.req_op    = op;
        bus.req_wide  = wide;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_wide  = 1'b1;
        bus.req_a     = 64'h1111_2222_3333_4444;
        bus.req_b     = 64'h5555_6666_7777_8888;
        bus.req_cin   = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_eq} !== 3'b000 || bus.rsp_result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid/cout/eq=%b%b%b result=%h expected 000 and 0",
                     bus.rsp_valid, bus.rsp_cout, bus.rsp_eq, bus.rsp_result);
        end
        n_checks++;
        if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0 || bus.alu_op !== 1'b0 || bus.alu_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu: a=%h b=%h op=%b cin=%b expected all 0",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
        end
        bus.req_valid = 1'b0;
        reset = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b expected 1", bus.req_ready);
        end
        tick();
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_precedence: req_ready=%b rsp_valid=%b expected 1 0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_narrow_add();
        int cyc;
        issue(1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        n_checks++;
        if (bus.alu_a !== 32'hFFFF_FFFF || bus.alu_b !== 32'h1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_lo_drive: alu_a=%h alu_b=%h req_ready=%b expected ffffffff 1 0",
                     bus.alu_a, bus.alu_b, bus.req_ready);
        end
        wait_rsp(cyc);
        n_checks++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL narrow_latency: cycles=%0d expected 1", cyc);
        end
        n_checks++;
        if (bus.rsp_result !== 64'h0 || bus.rsp_cout !== 1'b1 || bus.rsp_eq !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_add: result=%h cout=%b eq=%b expected 0 1 0",
                     bus.rsp_result, bus.rsp_cout, bus.rsp_eq);
        end
        n_checks++;
        if (bus.alu_a !== 32'h0 || bus.alu_op !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_alu_idle: alu_a=%h alu_op=%b expected 0 0", bus.alu_a, bus.alu_op);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_handshake: rsp_valid=%b req_ready=%b expected 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_wide_add();
        int cyc;
        issue(1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'h0 || bus.alu_cin !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_hi_drive: rsp_valid=%b alu_a=%h alu_cin=%b expected 0 0 1",
                     bus.rsp_valid, bus.alu_a, bus.alu_cin);
        end
        wait_rsp(cyc);
        n_checks++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL wide_latency: extra cycles after HI=%0d expected 1", cyc);
        end
        n_checks++;
        if (bus.rsp_result !== 64'h0000_0001_0000_0000 || bus.rsp_cout !== 1'b0 || bus.rsp_eq !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_add: result=%h cout=%b eq=%b expected 0000000100000000 0 0",
                     bus.rsp_result, bus.rsp_cout, bus.rsp_eq);
        end
        tick();
    endtask

    task automatic test_wide_nor();
        int cyc;
        issue(1'b1, 1'b1, 64'h0, 64'hFFFF_0000_0000_FFFF, 1'b1);
        n_checks++;
        if (bus.alu_op !== 1'b1 || bus.alu_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL nor_drive: alu_op=%b alu_cin=%b expected 1 0", bus.alu_op, bus.alu_cin);
        end
        wait_rsp(cyc);
        n_checks++;
        if (cyc != 2 || bus.rsp_result !== 64'h0000_FFFF_FFFF_0000 || bus.rsp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_nor: cycles=%0d result=%h cout=%b expected 2 0000ffffffff0000 0",
                     cyc, bus.rsp_result, bus.rsp_cout);
        end
        tick();
    endtask

    task automatic test_equality();
        int cyc;
        issue(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        wait_rsp(cyc);
        n_checks++;
        if (bus.rsp_eq !== 1'b1 || bus.rsp_result !== 64'h2468_ACF1_3579_BDE0 || bus.rsp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL eq_wide_same: eq=%b result=%h cout=%b expected 1 2468acf13579bde0 0",
                     bus.rsp_eq, bus.rsp_result, bus.rsp_cout);
        end
        tick();
        issue(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h9234_5678_9ABC_DEF0, 1'b0);
        wait_rsp(cyc);
        n_checks++;
        if (bus.rsp_eq !== 1'b0 || bus.rsp_result !== 64'hA468_ACF1_3579_BDE0) begin
            n_fail++;
            $display("FAIL eq_wide_bit63: eq=%b result=%h expected 0 a468acf13579bde0",
                     bus.rsp_eq, bus.rsp_result);
        end
        tick();
        issue(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h9234_5678_9ABC_DEF0, 1'b0);
        wait_rsp(cyc);
        n_checks++;
        if (bus.rsp_eq !== 1'b1 || bus.rsp_result !== 64'h0000_0000_3579_BDE0 || bus.rsp_cout !== 1'b1) begin
            n_fail++;
            $display("FAIL eq_narrow: eq=%b result=%h cout=%b expected 1 000000003579bde0 1",
                     bus.rsp_eq, bus.rsp_result, bus.rsp_cout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 64'h1, 64'h2, 1'b0);
        wait_rsp(cyc);
        bus.req_a     = 64'h55;
        bus.req_b     = 64'h66;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'h3 || bus.rsp_cout !== 1'b0 ||
                bus.rsp_eq !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b result=%h cout=%b eq=%b req_ready=%b expected 1 3 0 0 0",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.rsp_eq, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: rsp_valid=%b req_ready=%b expected 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_no_accept: rsp_valid=%b req_ready=%b expected 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_midop();
        int cyc;
        logic seen;
        issue(1'b0, 1'b1, 64'h0000_0005_FFFF_FFFF, 64'h1, 1'b0);
        tick();
        n_checks++;
        if (bus.alu_a !== 32'h5) begin
            n_fail++;
            $display("FAIL midop_in_hi: alu_a=%h expected 5", bus.alu_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 64'h0 ||
            bus.alu_a !== 32'h0 || bus.alu_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: req_ready=%b rsp_valid=%b result=%h alu_a=%h alu_cin=%b expected 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.alu_a, bus.alu_cin);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_response: response seen=%b expected 0", seen);
        end
        issue(1'b0, 1'b0, 64'h7, 64'h8, 1'b1);
        wait_rsp(cyc);
        n_checks++;
        if (cyc != 1 || bus.rsp_result !== 64'h10 || bus.rsp_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_followup: cycles=%0d result=%h cout=%b expected 1 10 0",
                     cyc, bus.rsp_result, bus.rsp_cout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_add();
        test_wide_nor();
        test_equality();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
